lsu_mem_stage: RTL and testbench

Load/store initiator for the 8-bit pipeline's MEM stage: accepts one load or store request per cycle from EX, drives the data-memory port (combinational read, write on posedge), and returns load results to writeback. Stores are absorbed into a small in-order store buffer and drained when the shared memory port is granted and not needed by a load. Loads get priority on the port.

---
 rtl/lsu_pkg.sv | 15 +
 rtl/lsu_store_buffer.sv | 96 +++++++++
 rtl/lsu_mem_stage.sv | 139 +++++++++++++
 tb/tb_lsu_mem_stage.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and default sizing for the MEM-stage load/store unit.
package lsu_pkg;

    localparam int unsigned ADDRESS_LINE = 8;
    localparam int unsigned DATA_W       = 8;
    localparam int unsigned RD_W_DEF     = 5;
    localparam int unsigned SB_DEPTH_DEF = 4;
    localparam int unsigned SB_CNT_W     = $clog2(SB_DEPTH_DEF + 1);

    typedef struct packed {
        logic [ADDRESS_LINE-1:0] address;
        logic [DATA_W-1:0]       data;
    } sb_entry_t;

endpackage

// File: rtl/lsu_store_buffer.sv
// In-order store buffer: circular FIFO with occupancy count.
// With STORE_FORWARD_EN defined it also reports the youngest entry matching a load address.
module lsu_store_buffer
    import lsu_pkg::*;
#(
    parameter int unsigned SB_DEPTH = SB_DEPTH_DEF,
    parameter int unsigned CNT_W    = $clog2(SB_DEPTH + 1)
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    push,
    input  sb_entry_t               push_entry,
    input  logic                    pop,
    output sb_entry_t               head_entry,
    output logic [CNT_W-1:0]        count,
    output logic                    full,
    output logic                    empty
`ifdef STORE_FORWARD_EN
    ,
    input  logic [ADDRESS_LINE-1:0] fwd_address,
    output logic                    fwd_hit,
    output logic [DATA_W-1:0]       fwd_data
`endif
);

    localparam int unsigned PTR_W = $clog2(SB_DEPTH);

    sb_entry_t          entries_q [SB_DEPTH];
    sb_entry_t          entries_d [SB_DEPTH];
    logic [PTR_W-1:0]   head_q, head_d;
    logic [PTR_W-1:0]   tail_q, tail_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               push_ok, pop_ok;

    assign full       = (count_q == CNT_W'(SB_DEPTH));
    assign empty      = (count_q == '0);
    assign count      = count_q;
    assign head_entry = entries_q[head_q];
    assign push_ok    = push & ~full;
    assign pop_ok     = pop & ~empty;

    // Pointer wrap relies on SB_DEPTH being a power of two.
    always_comb begin
        entries_d = entries_q;
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;
        if (push_ok) begin
            entries_d[tail_q] = push_entry;
            tail_d            = tail_q + PTR_W'(1);
        end
        if (pop_ok) begin
            head_d = head_q + PTR_W'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clock) begin
        entries_q <= entries_d;
    end

`ifdef STORE_FORWARD_EN
    logic [PTR_W-1:0] idx;

    // Walk oldest to youngest so the last match (youngest) wins; includes the head being drained.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        idx      = '0;
        for (int unsigned i = 0; i < SB_DEPTH; i++) begin
            idx = head_q + PTR_W'(i);
            if ((CNT_W'(i) < count_q) && (entries_q[idx].address == fwd_address)) begin
                fwd_hit  = 1'b1;
                fwd_data = entries_q[idx].data;
            end
        end
    end
`endif

endmodule

// File: rtl/lsu_mem_stage.sv
// MEM-stage load/store initiator: memory port mux, ready logic and load-return register.
// Store-to-load forwarding is built when STORE_FORWARD_EN is defined.
module lsu_mem_stage
    import lsu_pkg::*;
#(
    parameter int unsigned SB_DEPTH = SB_DEPTH_DEF,
    parameter int unsigned RD_W     = RD_W_DEF,
    localparam int unsigned CNT_W   = $clog2(SB_DEPTH + 1)
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_store,
    input  logic [ADDRESS_LINE-1:0] req_address,
    input  logic [DATA_W-1:0]       req_wdata,
    input  logic [RD_W-1:0]         req_rd,
    output logic                    wb_valid,
    output logic [RD_W-1:0]         wb_rd,
    output logic [DATA_W-1:0]       wb_data,
    input  logic                    mem_grant,
    output logic [ADDRESS_LINE-1:0] mem_address,
    output logic [DATA_W-1:0]       mem_write_data,
    output logic                    mem_write,
    output logic                    mem_read,
    input  logic [DATA_W-1:0]       mem_read_data,
    output logic                    sb_empty,
    output logic [CNT_W-1:0]        sb_count
);

    sb_entry_t          push_entry;
    sb_entry_t          head_entry;
    logic               sb_full;
    logic               sb_empty_int;
    logic               load_ready;
    logic               accept;
    logic               push;
    logic               load_fire;
    logic               load_miss;
    logic               drain;

    logic               wb_valid_q, wb_valid_d;
    logic [RD_W-1:0]    wb_rd_q, wb_rd_d;
    logic [DATA_W-1:0]  wb_data_q, wb_data_d;

`ifdef STORE_FORWARD_EN
    logic               fwd_hit;
    logic [DATA_W-1:0]  fwd_data;
`endif

    assign push_entry = '{address: req_address, data: req_wdata};

    lsu_store_buffer #(
        .SB_DEPTH (SB_DEPTH),
        .CNT_W    (CNT_W)
    ) u_store_buffer (
        .clock       (clock),
        .reset       (reset),
        .push        (push),
        .push_entry  (push_entry),
        .pop         (drain),
        .head_entry  (head_entry),
        .count       (sb_count),
        .full        (sb_full),
        .empty       (sb_empty_int)
`ifdef STORE_FORWARD_EN
        ,
        .fwd_address (req_address),
        .fwd_hit     (fwd_hit),
        .fwd_data    (fwd_data)
`endif
    );

    assign sb_empty = sb_empty_int;

    // Loads own the port when they miss; the buffer drains only in cycles a load leaves free.
    always_comb begin
        load_ready     = 1'b0;
        load_miss      = 1'b0;
        mem_address    = '0;
        mem_write_data = '0;
        wb_valid_d     = 1'b0;
        wb_rd_d        = wb_rd_q;
        wb_data_d      = wb_data_q;

`ifdef STORE_FORWARD_EN
        load_ready = fwd_hit | mem_grant;
`else
        load_ready = mem_grant & sb_empty_int;
`endif
        req_ready = ~reset & (req_store ? ~sb_full : load_ready);
        accept    = req_valid & req_ready;
        push      = accept & req_store;
        load_fire = accept & ~req_store;
`ifdef STORE_FORWARD_EN
        load_miss = load_fire & ~fwd_hit;
`else
        load_miss = load_fire;
`endif
        drain     = ~reset & mem_grant & ~sb_empty_int & ~load_miss;
        mem_read  = load_miss;
        mem_write = drain;

        if (load_miss) begin
            mem_address = req_address;
        end else if (drain) begin
            mem_address    = head_entry.address;
            mem_write_data = head_entry.data;
        end

        if (load_fire) begin
            wb_valid_d = 1'b1;
            wb_rd_d    = req_rd;
            wb_data_d  = mem_read_data;
`ifdef STORE_FORWARD_EN
            if (fwd_hit) begin
                wb_data_d = fwd_data;
            end
`endif
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wb_valid_q <= 1'b0;
            wb_rd_q    <= '0;
            wb_data_q  <= '0;
        end else begin
            wb_valid_q <= wb_valid_d;
            wb_rd_q    <= wb_rd_d;
            wb_data_q  <= wb_data_d;
        end
    end

    assign wb_valid = wb_valid_q;
    assign wb_rd    = wb_rd_q;
    assign wb_data  = wb_data_q;

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Self-checking bench for lsu_mem_stage: directed scenarios plus random traffic against a queue-based model.
module tb_lsu_mem_stage;

    localparam int unsigned SB_DEPTH = 4;
    localparam int unsigned RD_W     = 5;
    localparam int unsigned CNT_W    = $clog2(SB_DEPTH + 1);

    logic              clock;
    logic              reset;
    logic              req_valid;
    logic              req_ready;
    logic              req_store;
    logic [7:0]        req_address;
    logic [7:0]        req_wdata;
    logic [RD_W-1:0]   req_rd;
    logic              wb_valid;
    logic [RD_W-1:0]   wb_rd;
    logic [7:0]        wb_data;
    logic              mem_grant;
    logic [7:0]        mem_address;
    logic [7:0]        mem_write_data;
    logic              mem_write;
    logic              mem_read;
    logic [7:0]        mem_read_data;
    logic              sb_empty;
    logic [CNT_W-1:0]  sb_count;

    // Data memory seen by the DUT, and the memory image the model expects.
    logic [7:0] dmem [256];
    logic [7:0] rmem [256];

    // Model of the store buffer as an ordered list of pending stores.
    logic [7:0] qa [$];
    logic [7:0] qd [$];

    logic            exp_wb_valid;
    logic [RD_W-1:0] exp_wb_rd;
    logic [7:0]      exp_wb_data;
    logic            last_accept;
    int              n_cmp;
    int              n_fail;

    lsu_mem_stage #(
        .SB_DEPTH (SB_DEPTH),
        .RD_W     (RD_W)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_store      (req_store),
        .req_address    (req_address),
        .req_wdata      (req_wdata),
        .req_rd         (req_rd),
        .wb_valid       (wb_valid),
        .wb_rd          (wb_rd),
        .wb_data        (wb_data),
        .mem_grant      (mem_grant),
        .mem_address    (mem_address),
        .mem_write_data (mem_write_data),
        .mem_write      (mem_write),
        .mem_read       (mem_read),
        .mem_read_data  (mem_read_data),
        .sb_empty       (sb_empty),
        .sb_count       (sb_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    assign mem_read_data = dmem[mem_address];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive, check port outputs, clock, then check registered outputs.
    task automatic step(input logic v, input logic st, input logic [7:0] a, input logic [7:0] d,
                        input logic [RD_W-1:0] rd, input logic g, input logic rst);
        logic       hit;
        logic [7:0] fd;
        logic       s_ready, l_ready, e_ready, acc, lmiss, drn;
        logic [7:0] e_addr, e_wdata;
        logic       w_seen;
        logic [7:0] wa_seen, wd_seen;

        @(negedge clock);
        reset       = rst;
        req_valid   = v;
        req_store   = st;
        req_address = a;
        req_wdata   = d;
        req_rd      = rd;
        mem_grant   = g;
        #1;

        hit = 1'b0;
        fd  = 8'h00;
`ifdef STORE_FORWARD_EN
        for (int i = qa.size() - 1; i >= 0; i--) begin
            if (qa[i] == a) begin
                hit = 1'b1;
                fd  = qd[i];
                break;
            end
        end
        l_ready = hit || g;
`else
        l_ready = g && (qa.size() == 0);
`endif
        s_ready = (qa.size() < SB_DEPTH);
        e_ready = !rst && (st ? s_ready : l_ready);
        acc     = v && e_ready;
        lmiss   = acc && !st && !hit;
        drn     = !rst && g && (qa.size() > 0) && !lmiss;
        e_addr  = 8'h00;
        e_wdata = 8'h00;
        if (lmiss) begin
            e_addr = a;
        end else if (drn) begin
            e_addr  = qa[0];
            e_wdata = qd[0];
        end

        check("req_ready", 32'(req_ready), 32'(e_ready));
        check("mem_read", 32'(mem_read), 32'(lmiss));
        check("mem_write", 32'(mem_write), 32'(drn));
        check("mem_address", 32'(mem_address), 32'(e_addr));
        check("mem_write_data", 32'(mem_write_data), 32'(e_wdata));

        w_seen  = mem_write;
        wa_seen = mem_address;
        wd_seen = mem_write_data;

        @(posedge clock);
        #1;
        if (w_seen === 1'b1) dmem[wa_seen] = wd_seen;

        if (rst) begin
            qa.delete();
            qd.delete();
            exp_wb_valid = 1'b0;
            exp_wb_rd    = '0;
            exp_wb_data  = 8'h00;
        end else begin
            exp_wb_valid = acc && !st;
            if (exp_wb_valid) begin
                exp_wb_rd   = rd;
                exp_wb_data = hit ? fd : rmem[a];
            end
            if (drn) begin
                rmem[qa[0]] = qd[0];
                void'(qa.pop_front());
                void'(qd.pop_front());
            end
            if (acc && st) begin
                qa.push_back(a);
                qd.push_back(d);
            end
        end

        check("wb_valid", 32'(wb_valid), 32'(exp_wb_valid));
        if (rst || exp_wb_valid) begin
            check("wb_rd", 32'(wb_rd), 32'(exp_wb_rd));
            check("wb_data", 32'(wb_data), 32'(exp_wb_data));
        end
        check("sb_count", 32'(sb_count), 32'(qa.size()));
        check("sb_empty", 32'(sb_empty), 32'(qa.size() == 0));
        last_accept = acc;
    endtask

    // Hold one request until accepted, giving up after a bounded number of cycles.
    task automatic issue(input string tag, input logic st, input logic [7:0] a, input logic [7:0] d,
                         input logic [RD_W-1:0] rd, input logic g, input int bound);
        for (int n = 0; n < bound; n++) begin
            step(1'b1, st, a, d, rd, g, 1'b0);
            if (last_accept) break;
        end
        check({"accept_", tag}, 32'(last_accept), 32'd1);
    endtask

    task automatic idle(input logic g, input int cycles);
        for (int n = 0; n < cycles; n++) step(1'b0, 1'b0, 8'h00, 8'h00, '0, g, 1'b0);
    endtask

    initial begin
        int diff;
        logic [7:0] v8;

        n_cmp        = 0;
        n_fail       = 0;
        last_accept  = 1'b0;
        exp_wb_valid = 1'b0;
        exp_wb_rd    = '0;
        exp_wb_data  = 8'h00;
        reset        = 1'b1;
        req_valid    = 1'b0;
        req_store    = 1'b0;
        req_address  = 8'h00;
        req_wdata    = 8'h00;
        req_rd       = '0;
        mem_grant    = 1'b0;
        for (int i = 0; i < 256; i++) begin
            v8      = 8'($urandom);
            dmem[i] = v8;
            rmem[i] = v8;
        end
        dmem[8'h80] = 8'h7E;
        rmem[8'h80] = 8'h7E;

        // Reset state.
        step(1'b0, 1'b0, 8'h00, 8'h00, '0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 8'h00, 8'h00, '0, 1'b1, 1'b1);

        // Single store drains on the following idle cycle.
        step(1'b1, 1'b1, 8'h10, 8'h5A, '0, 1'b1, 1'b0);
        idle(1'b1, 2);

        // Reset discards three buffered stores; nothing is written afterwards.
        step(1'b1, 1'b1, 8'h50, 8'hA1, '0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 8'h51, 8'hA2, '0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 8'h52, 8'hA3, '0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 8'h00, 8'h00, '0, 1'b1, 1'b1);
        idle(1'b1, 3);

        // Fill the buffer without grant; the fifth store stalls until the first pop.
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 8'(8'h30 + i), 8'(i + 1), '0, 1'b0, 1'b0);
        issue("fifth_store", 1'b1, 8'h34, 8'h05, '0, 1'b1, 8);
        idle(1'b1, 5);
        for (int i = 0; i < 5; i++) issue("load_back", 1'b0, 8'(8'h30 + i), 8'h00, RD_W'(i + 8), 1'b1, 4);

        // Two stores to one address then a load of it without grant.
        step(1'b1, 1'b1, 8'h20, 8'h11, '0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 8'h20, 8'h22, '0, 1'b0, 1'b0);
        for (int n = 0; n < 3; n++) begin
            step(1'b1, 1'b0, 8'h20, 8'h00, RD_W'(3), 1'b0, 1'b0);
            if (last_accept) break;
        end
        if (!last_accept) issue("fwd_load", 1'b0, 8'h20, 8'h00, RD_W'(3), 1'b1, 10);
        idle(1'b1, 3);

        // Load miss with stores pending: the load takes the port first.
        step(1'b1, 1'b1, 8'h40, 8'hC1, '0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 8'h41, 8'hC2, '0, 1'b0, 1'b0);
        issue("load_miss", 1'b0, 8'h80, 8'h00, RD_W'(7), 1'b1, 10);
        idle(1'b1, 3);

        // Random traffic over a small address window to exercise forwarding and ordering.
        for (int n = 0; n < 400; n++) begin
            step(1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 1)),
                 8'(8'h20 + $urandom_range(0, 7)), 8'($urandom), RD_W'($urandom),
                 1'($urandom_range(0, 9) < 6), 1'($urandom_range(0, 99) < 2));
        end
        idle(1'b1, 8);

        diff = 0;
        for (int i = 0; i < 256; i++) if (dmem[i] !== rmem[i]) diff++;
        check("mem_image", 32'(diff), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
